// File: rtl/flapjack_char_arbiter_if.sv
// Client-side request bus of the character-write arbiter: per-client valid/ready
// plus packed column/row/character payloads, client i at slice [i*W +: W].
interface flapjack_char_arbiter_if #(
    parameter int N_CLIENTS = 4,
    parameter int X_W       = 7,
    parameter int Y_W       = 6,
    parameter int CHR_W     = 9
);
    logic [N_CLIENTS-1:0]       cl_valid;
    logic [N_CLIENTS-1:0]       cl_ready;
    logic [N_CLIENTS*X_W-1:0]   cl_x;
    logic [N_CLIENTS*Y_W-1:0]   cl_y;
    logic [N_CLIENTS*CHR_W-1:0] cl_chr;

    modport master (
        output cl_valid,
        output cl_x,
        output cl_y,
        output cl_chr,
        input  cl_ready
    );

    modport slave (
        input  cl_valid,
        input  cl_x,
        input  cl_y,
        input  cl_chr,
        output cl_ready
    );
endinterface

// File: rtl/flapjack_char_arbiter.sv
// Round-robin N-client arbiter feeding the textmode character-write port, with
// off-screen clipping (counted, not written) and optional strobe pacing.
module flapjack_char_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int X_W        = 7,
    parameter int Y_W        = 6,
    parameter int CHR_W      = 9,
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int STROBE_GAP = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk_sys,
    input  logic                   btn_rst_n,
    flapjack_char_arbiter_if.slave cl_bus,
    output logic [X_W-1:0]         char_x,
    output logic [Y_W-1:0]         char_y,
    output logic [CHR_W-1:0]       char_chr,
    output logic                   char_str,
    output logic [CNT_W-1:0]       clip_count,
    output logic                   busy
);
    localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int GAP_W = (STROBE_GAP > 0) ? $clog2(STROBE_GAP + 1) : 1;
    localparam logic [X_W:0]       COLS_L   = (X_W + 1)'(COLS);
    localparam logic [Y_W:0]       ROWS_L   = (Y_W + 1)'(ROWS);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(STROBE_GAP);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(N_CLIENTS - 1);

    typedef enum logic {ST_GRANT, ST_HOLDOFF} arb_state_t;

    arb_state_t           state;
    logic [PTR_W-1:0]     ptr;
    logic [GAP_W-1:0]     gap_cnt;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic                 grant_vld;
    logic [N_CLIENTS-1:0] ready_vec;
    logic                 take;
    logic                 clip;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [CHR_W-1:0]     sel_chr;

    // First valid client found scanning upward from ptr, wrapping at N_CLIENTS.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = PTR_W'((int'(ptr) + i) % N_CLIENTS);
            if (!grant_vld && cl_bus.cl_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (btn_rst_n && state == ST_GRANT && grant_vld)
            ready_vec[grant_idx] = 1'b1;
    end

    assign cl_bus.cl_ready = ready_vec;
    assign take     = |ready_vec;
    assign sel_x    = cl_bus.cl_x[grant_idx*X_W +: X_W];
    assign sel_y    = cl_bus.cl_y[grant_idx*Y_W +: Y_W];
    assign sel_chr  = cl_bus.cl_chr[grant_idx*CHR_W +: CHR_W];
    assign clip     = ({1'b0, sel_x} >= COLS_L) || ({1'b0, sel_y} >= ROWS_L);
    assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    assign busy     = btn_rst_n & ((|cl_bus.cl_valid) | char_str | (gap_cnt != '0));

    // Clipped grants still advance the pointer but neither strobe nor start a holdoff.
    always_ff @(posedge clk_sys or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state      <= ST_GRANT;
            ptr        <= '0;
            gap_cnt    <= '0;
            char_x     <= '0;
            char_y     <= '0;
            char_chr   <= '0;
            char_str   <= 1'b0;
            clip_count <= '0;
        end else begin
            char_str <= 1'b0;
            case (state)
                ST_GRANT: begin
                    if (take) begin
                        ptr <= next_ptr;
                        if (clip) begin
                            if (clip_count != '1)
                                clip_count <= clip_count + 1'b1;
                        end else begin
                            char_x   <= sel_x;
                            char_y   <= sel_y;
                            char_chr <= sel_chr;
                            char_str <= 1'b1;
                            if (STROBE_GAP > 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= ST_HOLDOFF;
                            end
                        end
                    end
                end
                ST_HOLDOFF: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_W'(1))
                        state <= ST_GRANT;
                end
                default: state <= ST_GRANT;
            endcase
        end
    end
endmodule

// File: tb/tb_flapjack_char_arbiter.sv
// Bench for flapjack_char_arbiter: instance 0 runs back-to-back (gap 0, 16-bit clip
// counter), instance 1 runs paced (gap 2, 4-bit clip counter), both against one model.
module tb_flapjack_char_arbiter;
    localparam int NC = 4;

    typedef struct {
        int         client;
        logic [6:0] x;
        logic [5:0] y;
        logic [8:0] chr;
        logic [3:0] exp_ready;
        logic       exp_str;
        logic [6:0] exp_x;
        logic [5:0] exp_y;
        logic [8:0] exp_chr;
        int         exp_clip;
    } dir_vec_t;

    logic clk_sys = 1'b0;
    logic btn_rst_n;

    logic [NC-1:0]   tb_valid [2];
    logic [NC*7-1:0] tb_x     [2];
    logic [NC*6-1:0] tb_y     [2];
    logic [NC*9-1:0] tb_chr   [2];

    flapjack_char_arbiter_if bus0 ();
    flapjack_char_arbiter_if bus1 ();

    assign bus0.cl_valid = tb_valid[0];
    assign bus0.cl_x     = tb_x[0];
    assign bus0.cl_y     = tb_y[0];
    assign bus0.cl_chr   = tb_chr[0];
    assign bus1.cl_valid = tb_valid[1];
    assign bus1.cl_x     = tb_x[1];
    assign bus1.cl_y     = tb_y[1];
    assign bus1.cl_chr   = tb_chr[1];

    logic [6:0]  char_x0, char_x1;
    logic [5:0]  char_y0, char_y1;
    logic [8:0]  char_chr0, char_chr1;
    logic        char_str0, char_str1;
    logic [15:0] clip_count0;
    logic [3:0]  clip_count1;
    logic        busy0, busy1;

    flapjack_char_arbiter #(.N_CLIENTS(NC), .STROBE_GAP(0), .CNT_W(16)) dut0 (
        .clk_sys(clk_sys), .btn_rst_n(btn_rst_n), .cl_bus(bus0),
        .char_x(char_x0), .char_y(char_y0), .char_chr(char_chr0), .char_str(char_str0),
        .clip_count(clip_count0), .busy(busy0)
    );

    flapjack_char_arbiter #(.N_CLIENTS(NC), .STROBE_GAP(2), .CNT_W(4)) dut1 (
        .clk_sys(clk_sys), .btn_rst_n(btn_rst_n), .cl_bus(bus1),
        .char_x(char_x1), .char_y(char_y1), .char_chr(char_chr1), .char_str(char_str1),
        .clip_count(clip_count1), .busy(busy1)
    );

    logic [3:0]  rdy  [2];
    logic [6:0]  ox   [2];
    logic [5:0]  oy   [2];
    logic [8:0]  ochr [2];
    logic        ostr [2];
    logic [15:0] oclip[2];
    logic        obusy[2];

    assign rdy[0]   = bus0.cl_ready;
    assign rdy[1]   = bus1.cl_ready;
    assign ox[0]    = char_x0;
    assign ox[1]    = char_x1;
    assign oy[0]    = char_y0;
    assign oy[1]    = char_y1;
    assign ochr[0]  = char_chr0;
    assign ochr[1]  = char_chr1;
    assign ostr[0]  = char_str0;
    assign ostr[1]  = char_str1;
    assign oclip[0] = clip_count0;
    assign oclip[1] = {12'd0, clip_count1};
    assign obusy[0] = busy0;
    assign obusy[1] = busy1;

    always #5 clk_sys = ~clk_sys;

    int         m_ptr [2];
    int         m_gap [2];
    int         m_clip[2];
    logic       m_str [2];
    logic [6:0] m_x   [2];
    logic [5:0] m_y   [2];
    logic [8:0] m_chr [2];
    logic [3:0] m_acc [2];

    int n_vectors     = 0;
    int n_miscompares = 0;

    dir_vec_t   dir_tab [6];
    logic [3:0] rr_exp0 [7];
    logic       str_exp0[7];
    logic [3:0] rr_exp1 [7];
    logic       str_exp1[7];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int clip_max(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic int first_valid(input logic [3:0] v, input int p);
        for (int k = 0; k < NC; k++)
            if (v[(p + k) % NC]) return (p + k) % NC;
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input int d);
        int g;
        if (btn_rst_n !== 1'b1 || m_gap[d] != 0) return 4'b0000;
        g = first_valid(tb_valid[d], m_ptr[d]);
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                               input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s dut%0d @%0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic checkAll();
        logic exp_busy;
        for (int d = 0; d < 2; d++) begin
            exp_busy = (btn_rst_n === 1'b1) && ((|tb_valid[d]) || m_str[d] || m_gap[d] != 0);
            checkOutput("cl_ready",   d, 32'(rdy[d]),   32'(model_ready(d)));
            checkOutput("char_str",   d, 32'(ostr[d]),  32'(m_str[d]));
            checkOutput("char_x",     d, 32'(ox[d]),    32'(m_x[d]));
            checkOutput("char_y",     d, 32'(oy[d]),    32'(m_y[d]));
            checkOutput("char_chr",   d, 32'(ochr[d]),  32'(m_chr[d]));
            checkOutput("clip_count", d, 32'(oclip[d]), 32'(m_clip[d]));
            checkOutput("busy",       d, 32'(obusy[d]), 32'(exp_busy));
        end
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_gap[d] = 0; m_clip[d] = 0; m_str[d] = 1'b0;
            m_x[d] = '0; m_y[d] = '0; m_chr[d] = '0; m_acc[d] = '0;
        end
    endtask

    // One accepted request per instance per edge; off-screen requests only bump the counter.
    task automatic modelEdge();
        int         g;
        logic [6:0] x;
        logic [5:0] y;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = '0;
            if (btn_rst_n !== 1'b1) continue;
            m_str[d] = 1'b0;
            if (m_gap[d] > 0) begin
                m_gap[d]--;
            end else begin
                g = first_valid(tb_valid[d], m_ptr[d]);
                if (g >= 0) begin
                    m_acc[d][g] = 1'b1;
                    x = tb_x[d][g*7 +: 7];
                    y = tb_y[d][g*6 +: 6];
                    m_ptr[d] = (g + 1) % NC;
                    if (x >= 80 || y >= 60) begin
                        if (m_clip[d] < clip_max(d)) m_clip[d]++;
                    end else begin
                        m_str[d] = 1'b1;
                        m_x[d]   = x;
                        m_y[d]   = y;
                        m_chr[d] = tb_chr[d][g*9 +: 9];
                        m_gap[d] = gap_of(d);
                    end
                end
            end
        end
    endtask

    task automatic runCycle();
        checkAll();
        @(posedge clk_sys);
        modelEdge();
        @(negedge clk_sys);
    endtask

    task automatic newPayload(input int d, input int c, input bit allow_clip);
        tb_x[d][c*7 +: 7]   = allow_clip ? 7'($urandom_range(0, 95)) : 7'($urandom_range(0, 79));
        tb_y[d][c*6 +: 6]   = allow_clip ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
        tb_chr[d][c*9 +: 9] = 9'($urandom);
    endtask

    task automatic refillAccepted(input int d);
        for (int c = 0; c < NC; c++)
            if (m_acc[d][c]) newPayload(d, c, 1'b0);
    endtask

    task automatic randomDrive();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                if (m_acc[d][c] || !tb_valid[d][c]) begin
                    tb_valid[d][c] = ($urandom_range(0, 2) != 0);
                    if (tb_valid[d][c]) newPayload(d, c, 1'b1);
                end
            end
        end
    endtask

    task automatic doReset();
        #2 btn_rst_n = 1'b0;
        resetModel();
        #1;
        checkAll();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ready", d, 32'(rdy[d]),   32'd0);
            checkOutput("rst_str",   d, 32'(ostr[d]),  32'd0);
            checkOutput("rst_clip",  d, 32'(oclip[d]), 32'd0);
            checkOutput("rst_busy",  d, 32'(obusy[d]), 32'd0);
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        btn_rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input dir_vec_t v);
        tb_valid[0] = 4'b0001 << v.client;
        tb_valid[1] = 4'b0000;
        tb_x[0][v.client*7 +: 7]   = v.x;
        tb_y[0][v.client*6 +: 6]   = v.y;
        tb_chr[0][v.client*9 +: 9] = v.chr;
    endtask

    initial begin
        dir_tab[0] = '{1,  7'd5,   6'd3,  9'h041, 4'b0010, 1'b1, 7'd5,  6'd3,  9'h041, 0};
        dir_tab[1] = '{0,  7'd80,  6'd0,  9'h011, 4'b0001, 1'b0, 7'd5,  6'd3,  9'h041, 1};
        dir_tab[2] = '{3,  7'd0,   6'd60, 9'h022, 4'b1000, 1'b0, 7'd5,  6'd3,  9'h041, 2};
        dir_tab[3] = '{2,  7'd79,  6'd59, 9'h1FF, 4'b0100, 1'b1, 7'd79, 6'd59, 9'h1FF, 2};
        dir_tab[4] = '{0,  7'd127, 6'd63, 9'h000, 4'b0001, 1'b0, 7'd79, 6'd59, 9'h1FF, 3};
        dir_tab[5] = '{3,  7'd0,   6'd0,  9'h100, 4'b1000, 1'b1, 7'd0,  6'd0,  9'h100, 3};
        rr_exp0  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        str_exp0 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        rr_exp1  = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
        str_exp1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        btn_rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tb_valid[d] = '0; tb_x[d] = '0; tb_y[d] = '0; tb_chr[d] = '0;
        end
        resetModel();
        doReset();

        $display("[TB] directed single requests and clipping");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(dir_tab[r]);
            #1;
            checkOutput("tab_ready", 0, 32'(rdy[0]), 32'(dir_tab[r].exp_ready));
            runCycle();
            tb_valid[0] = '0;
            #1;
            checkOutput("tab_str",  0, 32'(ostr[0]),  32'(dir_tab[r].exp_str));
            checkOutput("tab_x",    0, 32'(ox[0]),    32'(dir_tab[r].exp_x));
            checkOutput("tab_y",    0, 32'(oy[0]),    32'(dir_tab[r].exp_y));
            checkOutput("tab_chr",  0, 32'(ochr[0]),  32'(dir_tab[r].exp_chr));
            checkOutput("tab_clip", 0, 32'(oclip[0]), dir_tab[r].exp_clip);
        end

        $display("[TB] mid-stream reset, round-robin order and strobe pacing");
        tb_valid[0] = 4'hF;
        tb_valid[1] = 4'hF;
        for (int c = 0; c < NC; c++) begin
            newPayload(0, c, 1'b0);
            newPayload(1, c, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            runCycle();
            refillAccepted(0);
            refillAccepted(1);
        end
        doReset();
        tb_valid[1] = 4'b0011;
        for (int k = 0; k < 7; k++) begin
            #1;
            checkOutput("rr_order", 0, 32'(rdy[0]),  32'(rr_exp0[k]));
            checkOutput("rr_str",   0, 32'(ostr[0]), 32'(str_exp0[k]));
            checkOutput("gap_rdy",  1, 32'(rdy[1]),  32'(rr_exp1[k]));
            checkOutput("gap_str",  1, 32'(ostr[1]), 32'(str_exp1[k]));
            runCycle();
            refillAccepted(0);
            refillAccepted(1);
        end

        $display("[TB] late-arriving client after a grant");
        tb_valid[0] = '0;
        tb_valid[1] = '0;
        doReset();
        for (int c = 0; c < NC; c++) newPayload(0, c, 1'b0);
        tb_valid[0] = 4'b0100;
        #1;
        checkOutput("late_rdy0", 0, 32'(rdy[0]), 32'(4'b0100));
        runCycle();
        tb_valid[0] = 4'b0011;
        #1;
        checkOutput("late_rdy1", 0, 32'(rdy[0]), 32'(4'b0001));
        runCycle();
        newPayload(0, 2, 1'b0);
        tb_valid[0] = 4'b0110;
        #1;
        checkOutput("late_rdy2", 0, 32'(rdy[0]), 32'(4'b0010));
        runCycle();

        $display("[TB] clip counter saturation");
        tb_valid[0] = 4'b0001;
        tb_x[0][0 +: 7] = 7'd100;
        tb_valid[1] = 4'b1000;
        tb_x[1][21 +: 7] = 7'd100;
        for (int k = 0; k < 20; k++) begin
            #1;
            runCycle();
        end
        tb_valid[0] = '0;
        tb_valid[1] = '0;
        #1;
        checkOutput("clip_cnt", 0, 32'(oclip[0]), 32'd20);
        checkOutput("clip_sat", 1, 32'(oclip[1]), 32'd15);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            randomDrive();
            #1;
            runCycle();
        end
        tb_valid[0] = '0;
        tb_valid[1] = '0;
        #1;
        checkAll();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
